varredor_canais: RTL and testbench

Sequential channel scanner that sits directly upstream of the 8-channel mux: it drives the mux `seletor`, waits for the selected channel to settle, captures the mux output and delivers each sample downstream with its channel number over a valid/ready handshake. One sweep visits every enabled channel in ascending order (0→7). It can run a single sweep per start pulse or sweep continuously.

---
 rtl/varredor_pkg.sv | 7 +
 rtl/varredor_canais_busca.sv | 20 ++
 rtl/varredor_canais.sv | 96 +++++++++
 tb/tb_varredor_canais.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/varredor_pkg.sv
// varredor_pkg: shared state type and sizing constants for the channel scanner
package varredor_pkg;
  localparam int NUM_CANAIS = 8;
  localparam int LARGURA_SEL = 3;
  localparam int LARGURA_CONT = 4;
  typedef enum logic [1:0] {OCIOSO, ESPERA, ENVIA} estado_t;
endpackage

// File: rtl/varredor_canais_busca.sv
// busca_proximo_canal: lowest enabled channel, either from channel 0 or strictly above atual
module busca_proximo_canal
  import varredor_pkg::*;
(
  input  logic [NUM_CANAIS-1:0]  mascara,
  input  logic [LARGURA_SEL-1:0] atual,
  input  logic                   do_inicio,
  output logic [LARGURA_SEL-1:0] proximo,
  output logic                   achou
);
  always_comb begin
    proximo = '0;
    achou = 1'b0;
    for (int i = NUM_CANAIS - 1; i >= 0; i--)
      if (mascara[i] && (do_inicio || i > int'(atual))) begin
        proximo = LARGURA_SEL'(i);
        achou = 1'b1;
      end
  end
endmodule

// File: rtl/varredor_canais.sv
// varredor_canais: sequential scanner driving the 8-channel mux select and streaming samples out.
// Define VARREDOR_MASCARA_EN to add the mascara channel-enable port; otherwise all channels are enabled.
module varredor_canais
  import varredor_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int TEMPO_ESPERA = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic                   continuo,
`ifdef VARREDOR_MASCARA_EN
  input  logic [NUM_CANAIS-1:0]  mascara,
`endif
  output logic [LARGURA_SEL-1:0] seletor,
  input  logic [LARGURA-1:0]     dado_mux,
  output logic [LARGURA-1:0]     saida_dado,
  output logic [LARGURA_SEL-1:0] saida_canal,
  output logic                   saida_valida,
  input  logic                   saida_pronta,
  output logic                   ocupado,
  output logic                   fim_varredura
);
  localparam logic [LARGURA_CONT-1:0] RECARGA = LARGURA_CONT'(TEMPO_ESPERA);
  estado_t estado;
  logic [LARGURA_CONT-1:0] contador;
  logic [NUM_CANAIS-1:0] habilita;
  logic [LARGURA_SEL-1:0] primeiro, proximo;
  logic achou_primeiro, achou_proximo;
`ifdef VARREDOR_MASCARA_EN
  assign habilita = mascara;
`else
  assign habilita = '1;
`endif
  busca_proximo_canal u_primeiro (
    .mascara(habilita), .atual(seletor), .do_inicio(1'b1),
    .proximo(primeiro), .achou(achou_primeiro)
  );
  busca_proximo_canal u_proximo (
    .mascara(habilita), .atual(seletor), .do_inicio(1'b0),
    .proximo(proximo), .achou(achou_proximo)
  );
  assign ocupado = estado != OCIOSO;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      estado <= OCIOSO;
      contador <= '0;
      seletor <= '0;
      saida_dado <= '0;
      saida_canal <= '0;
      saida_valida <= 1'b0;
      fim_varredura <= 1'b0;
    end else begin
      fim_varredura <= 1'b0;
      case (estado)
        OCIOSO:
          if (iniciar) begin
            if (achou_primeiro) begin
              seletor <= primeiro;
              contador <= RECARGA;
              estado <= ESPERA;
            end else
              fim_varredura <= 1'b1;
          end
        ESPERA: begin
          contador <= contador - 1'b1;
          if (contador == LARGURA_CONT'(1)) begin
            saida_dado <= dado_mux;
            saida_canal <= seletor;
            saida_valida <= 1'b1;
            estado <= ENVIA;
          end
        end
        ENVIA:
          if (saida_pronta) begin
            saida_valida <= 1'b0;
            if (achou_proximo) begin
              seletor <= proximo;
              contador <= RECARGA;
              estado <= ESPERA;
            end else begin
              fim_varredura <= 1'b1;
              // a restart with nothing enabled falls back to idle
              if (continuo && achou_primeiro) begin
                seletor <= primeiro;
                contador <= RECARGA;
                estado <= ESPERA;
              end else
                estado <= OCIOSO;
            end
          end
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_varredor_canais.sv
// tb_varredor_canais: directed sweeps with random mux data, backpressure and busy-time starts
module tb_varredor_canais;
  localparam int LARG = 8;
  localparam int TE = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic iniciar = 1'b0;
  logic continuo = 1'b0;
  logic saida_pronta = 1'b1;
  logic [7:0] mascara = 8'hFF;
  logic [2:0] seletor, saida_canal;
  logic [LARG-1:0] mux [8];
  logic [LARG-1:0] dado_mux, saida_dado;
  logic saida_valida, ocupado, fim_varredura;
  int checks = 0;
  int failures = 0;

  assign dado_mux = mux[seletor];
  always #5 clock = ~clock;

  varredor_canais #(.LARGURA(LARG), .TEMPO_ESPERA(TE)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .continuo(continuo),
`ifdef VARREDOR_MASCARA_EN
    .mascara(mascara),
`endif
    .seletor(seletor),
    .dado_mux(dado_mux),
    .saida_dado(saida_dado),
    .saida_canal(saida_canal),
    .saida_valida(saida_valida),
    .saida_pronta(saida_pronta),
    .ocupado(ocupado),
    .fim_varredura(fim_varredura)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int primeiro(input logic [7:0] m);
    for (int i = 0; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int seguinte(input logic [7:0] m, input int c);
    for (int i = c + 1; i < 8; i++) if (m[i]) return i;
    return -1;
  endfunction

  task automatic embaralha();
    for (int i = 0; i < 8; i++) mux[i] = LARG'($urandom);
  endtask

  // nvarr sweeps (continuous until the last one); muda randomizes the mask during backpressure
  task automatic varre(input int nvarr, input bit muda);
    int c;
    logic [LARG-1:0] esperado;
    continuo = nvarr > 1;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    c = primeiro(mascara);
    if (c < 0) begin
      chk("fim_vazio", 32'(fim_varredura), 1);
      chk("ocupado_vazio", 32'(ocupado), 0);
      @(negedge clock);
      chk("fim_vazio_pulso", 32'(fim_varredura), 0);
      return;
    end
    for (int s = 0; s < nvarr; s++) begin
      while (c >= 0) begin
        chk("seletor", 32'(seletor), c);
        chk("valida_espera", 32'(saida_valida), 0);
        chk("ocupado", 32'(ocupado), 1);
        if (s == nvarr - 1) continuo = 1'b0;
        repeat (TE - 1) begin
          @(negedge clock);
          chk("valida_cedo", 32'(saida_valida), 0);
        end
        esperado = mux[c];
        @(negedge clock);
        chk("valida", 32'(saida_valida), 1);
        chk("canal", 32'(saida_canal), c);
        chk("dado", 32'(saida_dado), 32'(esperado));
        saida_pronta = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          embaralha();
          iniciar = 1'($urandom_range(0, 1));
          if (muda) mascara = 8'($urandom);
          @(negedge clock);
          chk("segura_valida", 32'(saida_valida), 1);
          chk("segura_canal", 32'(saida_canal), c);
          chk("segura_dado", 32'(saida_dado), 32'(esperado));
          chk("segura_seletor", 32'(seletor), c);
        end
        iniciar = 1'b0;
        saida_pronta = 1'b1;
        @(negedge clock);
        chk("valida_baixa", 32'(saida_valida), 0);
        c = seguinte(mascara, c);
        if (c >= 0) chk("fim_meio", 32'(fim_varredura), 0);
      end
      chk("fim", 32'(fim_varredura), 1);
      c = (s < nvarr - 1) ? primeiro(mascara) : -1;
      if (c < 0) begin
        chk("ocupado_fim", 32'(ocupado), 0);
        @(negedge clock);
        chk("fim_pulso", 32'(fim_varredura), 0);
        chk("ocioso", 32'(ocupado), 0);
        return;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mux[i] = LARG'(8'h10 + i);
    @(negedge clock);
    chk("rst_seletor", 32'(seletor), 0);
    chk("rst_dado", 32'(saida_dado), 0);
    chk("rst_canal", 32'(saida_canal), 0);
    chk("rst_valida", 32'(saida_valida), 0);
    chk("rst_ocupado", 32'(ocupado), 0);
    chk("rst_fim", 32'(fim_varredura), 0);
    reset = 1'b0;
    @(negedge clock);
    varre(1, 1'b0);
    chk("seletor_retido", 32'(seletor), 7);
    embaralha();
    varre(1, 1'b0);
    embaralha();
    varre(3, 1'b0);
    saida_pronta = 1'b0;
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    repeat (TE + 1) @(negedge clock);
    chk("pre_reset_valida", 32'(saida_valida), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_valida", 32'(saida_valida), 0);
    chk("async_seletor", 32'(seletor), 0);
    chk("async_dado", 32'(saida_dado), 0);
    chk("async_canal", 32'(saida_canal), 0);
    chk("async_ocupado", 32'(ocupado), 0);
    chk("async_fim", 32'(fim_varredura), 0);
    @(negedge clock);
    reset = 1'b0;
    saida_pronta = 1'b1;
    embaralha();
    varre(1, 1'b0);
`ifdef VARREDOR_MASCARA_EN
    mascara = 8'b1010_0100;
    varre(1, 1'b0);
    mascara = 8'h81;
    varre(3, 1'b0);
    mascara = 8'h00;
    varre(1, 1'b0);
    chk("vazio_ocioso", 32'(ocupado), 0);
    for (int k = 0; k < 6; k++) begin
      mascara = 8'($urandom);
      embaralha();
      varre(2, 1'b1);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
